// File: rtl/apb_master.sv
// apb_master: single-outstanding APB bridge.
// Accepts one command on a valid/ready port. Runs an APB SETUP/ACCESS
// transfer to slave cmd_id (1..3) and returns one response strobe per command.
// An id of 0 is answered with an error response and causes no bus activity.
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_write, cmd_id[1:0], cmd_addr, cmd_wdata : command port
//   rsp_valid, rsp_rdata, rsp_err                                     : response port
//   psel[1:0], penable, pwrite, paddr, pwdata, prdata, pready         : APB bus
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// with rsp_err after TIMEOUT cycles that have pready low.
module apb_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_id,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_d;
  logic                rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_d;
  logic                rsp_err_d;
  logic [1:0]          psel_d;
  logic                penable_d;
  logic                pwrite_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [DATA_W-1:0]   pwdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt_q, wait_cnt_d;
`endif

  // Every output is a flop; the comb block computes each one's next value.
  // The APB address/data/direction flops double as the command latch.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_id != 2'd0) begin
            psel_d   = cmd_id;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
            state_d  = SETUP;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          if (!pwrite) begin
            rsp_rdata_d = prdata;
          end
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 2'd0;
          penable_d   = 1'b0;
          state_d     = DONE;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 2'd0;
          penable_d   = 1'b0;
          state_d     = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 2'd0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: self-checking bench for apb_master.
// Directed table of transfers, timeout corner cases (when APB_MASTER_TIMEOUT_EN
// is defined), a mid-ACCESS reset sequence, and random transfers checked
// against a transaction-level latency/response model.
module tb_apb_master;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO     = 4;
  localparam bit TO_EN  = 1'b1;
`else
  localparam int TO     = 16;
  localparam bit TO_EN  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [1:0] cmd_id;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic [1:0] psel;
  logic       penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " psel"},      32'(psel),      32'd0);
    check({tag, " penable"},   32'(penable),   32'd0);
    check({tag, " pwrite"},    32'(pwrite),    32'd0);
    check({tag, " paddr"},     32'(paddr),     32'd0);
    check({tag, " pwdata"},    32'(pwdata),    32'd0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, " rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  // Runs one command from an IDLE sample point. waits = number of ACCESS
  // cycles with pready low before it rises; early drives pready high through
  // IDLE and SETUP. e_lat = cycles from the accept edge to the rsp_valid cycle.
  task automatic run_txn(input string tag, input bit w, input logic [1:0] id,
                         input logic [7:0] a, input logic [7:0] wd, input logic [7:0] rd,
                         input int waits, input bit early, input bit e_err,
                         input logic [7:0] e_rdata, input int e_lat);
    int c;
    bit seen;
    int n_psel;
    int n_pen;
    check({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_id = id; cmd_addr = a; cmd_wdata = wd;
    pready = early; prdata = 8'($urandom);
    tick();
    // Scramble the command bus so a design that fails to latch is exposed.
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_id = 2'($urandom);
    cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    seen = 1'b0; n_psel = 0; n_pen = 0; c = 0;
    while (!seen && c <= e_lat + 8) begin
      if (rsp_valid) begin
        seen = 1'b1;
        check({tag, " rsp_latency"}, 32'(c),         32'(e_lat));
        check({tag, " rsp_err"},     32'(rsp_err),   32'(e_err));
        check({tag, " rsp_rdata"},   32'(rsp_rdata), 32'(e_rdata));
        check({tag, " done_psel"},   32'(psel),      32'd0);
        check({tag, " done_penable"},32'(penable),   32'd0);
        check({tag, " done_ready"},  32'(cmd_ready), 32'd0);
      end else begin
        if (psel != 2'd0) begin
          n_psel++;
          check({tag, " psel_id"}, 32'(psel),   32'(id));
          check({tag, " paddr"},   32'(paddr),  32'(a));
          check({tag, " pwrite"},  32'(pwrite), 32'(w));
          if (w) check({tag, " pwdata"}, 32'(pwdata), 32'(wd));
        end
        if (penable) n_pen++;
        pready = (c >= 1 && c - 1 == waits) || (early && c == 0);
        prdata = pready ? rd : 8'($urandom);
        tick();
        c++;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s rsp_timeout: got no rsp_valid within %0d cycles, required at %0d", tag, c, e_lat);
    end
    check({tag, " psel_cycles"},    32'(n_psel), (id == 2'd0) ? 32'd0 : 32'(e_lat));
    check({tag, " penable_cycles"}, 32'(n_pen),  (id == 2'd0) ? 32'd0 : 32'(e_lat - 1));
    pready = 1'b0;
    tick();
    check({tag, " rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, " ready_back"},     32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    bit         w;
    logic [1:0] id;
    logic [7:0] a;
    logic [7:0] wd;
    logic [7:0] rd;
    int         waits;
    bit         early;
    bit         e_err;
    logic [7:0] e_rdata;
    int         e_lat;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] m_rdata;

  initial begin
    bit         w;
    logic [1:0] id;
    logic [7:0] a, wd, rd;
    int         waits;
    bit         early, e_err, tmo;
    int         e_lat;

    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = 2'd0;
    cmd_addr = '0; cmd_wdata = '0; prdata = '0; pready = 1'b0;

    tbl[0] = '{1'b1, 2'd2, 8'h15, 8'hA5, 8'h00, 0, 1'b0, 1'b0, 8'h00, 2};
    tbl[1] = '{1'b0, 2'd1, 8'h03, 8'h00, 8'h5C, 3, 1'b0, 1'b0, 8'h5C, 5};
    tbl[2] = '{1'b0, 2'd3, 8'h7E, 8'h00, 8'h33, 0, 1'b1, 1'b0, 8'h33, 2};
    tbl[3] = '{1'b1, 2'd0, 8'h44, 8'h12, 8'h00, 0, 1'b0, 1'b1, 8'h33, 0};
    tbl[4] = '{1'b1, 2'd1, 8'h80, 8'h0F, 8'h00, 1, 1'b0, 1'b0, 8'h33, 3};
    tbl[5] = '{1'b0, 2'd2, 8'hFF, 8'h00, 8'hC3, 2, 1'b0, 1'b0, 8'hC3, 4};

    tick(); tick();
    check_reset_vals("in_reset");
    reset = 1'b1;
    tick();
    check_reset_vals("after_release");

    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].w, tbl[i].id, tbl[i].a, tbl[i].wd,
              tbl[i].rd, tbl[i].waits, tbl[i].early, tbl[i].e_err,
              tbl[i].e_rdata, tbl[i].e_lat);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // pready never rises: 4 ACCESS cycles then error, read data untouched.
    run_txn("timeout", 1'b0, 2'd1, 8'h21, 8'h00, 8'h99, 1000, 1'b0, 1'b1, 8'hC3, 5);
    // pready on the 4th ACCESS cycle wins over the abort.
    run_txn("timeout_edge", 1'b0, 2'd1, 8'h22, 8'h00, 8'h6A, 3, 1'b0, 1'b0, 8'h6A, 5);
`endif

    // Reset in the second ACCESS cycle.
    check("rst_seq cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_id = 2'd3; cmd_addr = 8'h5A; cmd_wdata = 8'h77;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rst_seq access1 penable", 32'(penable), 32'd1);
    tick();
    check("rst_seq access2 psel", 32'(psel), 32'd3);
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals("mid_access_reset");
    tick();
    check("rst_hold rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("rst_after rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_after psel", 32'(psel), 32'd0);
    run_txn("post_reset_write", 1'b1, 2'd2, 8'h31, 8'hE4, 8'h00, 1, 1'b0, 1'b0, 8'h00, 3);

    // Random transfers against a transaction-level model.
    m_rdata = 8'h00;
    for (int i = 0; i < 40; i++) begin
      w     = 1'($urandom);
      id    = 2'($urandom_range(0, 3));
      a     = 8'($urandom);
      wd    = 8'($urandom);
      rd    = 8'($urandom);
      waits = $urandom_range(0, 3);
      early = 1'($urandom);
      tmo   = TO_EN && (waits >= TO);
      if (id == 2'd0) begin
        e_err = 1'b1;
        e_lat = 0;
      end else if (tmo) begin
        e_err = 1'b1;
        e_lat = TO + 1;
      end else begin
        e_err = 1'b0;
        e_lat = waits + 2;
        if (!w) m_rdata = rd;
      end
      run_txn($sformatf("rnd%0d", i), w, id, a, wd, rd, waits, early, e_err, m_rdata, e_lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
